// File: rtl/tdm_demux4.sv
// Four-channel TDM demultiplexer with a HUNT/LOCKED frame-alignment FSM.
// Define TDM_DEMUX_FRAME_LATCH_EN to publish whole frames at once instead of per-slot updates.
module tdm_demux4 #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [WIDTH-1:0]   din,
   input  logic               din_valid,
   input  logic               frame_sync,
   output logic [4*WIDTH-1:0] dout,
   output logic [3:0]         ch_valid,
   output logic               frame_done,
   output logic               locked,
   output logic               sync_err
);

   localparam logic [0:0] ST_HUNT   = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   logic [0:0]         state_r;
   logic [1:0]         slot_r;
   logic [4*WIDTH-1:0] dout_r;
   logic [3:0]         ch_valid_r;
   logic               frame_done_r;
   logic               sync_err_r;

   logic [0:0]         state_nxt_s;
   logic [1:0]         slot_nxt_s;
   logic               wr_en_s;
   logic [1:0]         wr_ch_s;
   logic               done_s;
   logic               err_s;

   // Next-state decode: which channel a beat writes and which strobes it raises.
   always_comb begin
      state_nxt_s = state_r;
      slot_nxt_s  = slot_r;
      wr_en_s     = 1'b0;
      wr_ch_s     = 2'd0;
      done_s      = 1'b0;
      err_s       = 1'b0;
      if (din_valid) begin
         case (state_r)
            ST_HUNT: begin
               if (frame_sync) begin
                  state_nxt_s = ST_LOCKED;
                  slot_nxt_s  = 2'd1;
                  wr_en_s     = 1'b1;
                  wr_ch_s     = 2'd0;
               end else begin
                  state_nxt_s = ST_HUNT;
               end
            end
            ST_LOCKED: begin
               if (frame_sync) begin
                  // A sync away from slot 0 restarts the frame on this word.
                  err_s      = (slot_r != 2'd0);
                  slot_nxt_s = 2'd1;
                  wr_en_s    = 1'b1;
                  wr_ch_s    = 2'd0;
               end else if (slot_r == 2'd0) begin
                  err_s       = 1'b1;
                  state_nxt_s = ST_HUNT;
                  slot_nxt_s  = 2'd0;
               end else begin
                  wr_en_s    = 1'b1;
                  wr_ch_s    = slot_r;
                  slot_nxt_s = slot_r + 2'd1;
                  done_s     = (slot_r == 2'd3);
               end
            end
            default: begin
               state_nxt_s = ST_HUNT;
               slot_nxt_s  = 2'd0;
            end
         endcase
      end else begin
         state_nxt_s = state_r;
         slot_nxt_s  = slot_r;
      end
   end

   // Alignment state and the single-cycle event strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= ST_HUNT;
         slot_r       <= 2'd0;
         frame_done_r <= 1'b0;
         sync_err_r   <= 1'b0;
      end else begin
         state_r      <= state_nxt_s;
         slot_r       <= slot_nxt_s;
         frame_done_r <= done_s;
         sync_err_r   <= err_s;
      end
   end

`ifdef TDM_DEMUX_FRAME_LATCH_EN
   logic [WIDTH-1:0] shadow0_r;
   logic [WIDTH-1:0] shadow1_r;
   logic [WIDTH-1:0] shadow2_r;

   // Slots 0..2 wait in shadow registers; slot 3 of a good frame publishes all four.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow0_r  <= {WIDTH{1'b0}};
         shadow1_r  <= {WIDTH{1'b0}};
         shadow2_r  <= {WIDTH{1'b0}};
         dout_r     <= {(4*WIDTH){1'b0}};
         ch_valid_r <= 4'b0000;
      end else begin
         if (wr_en_s) begin
            case (wr_ch_s)
               2'd0:    shadow0_r <= din;
               2'd1:    shadow1_r <= din;
               2'd2:    shadow2_r <= din;
               default: shadow2_r <= shadow2_r;
            endcase
         end
         if (done_s) begin
            dout_r     <= {din, shadow2_r, shadow1_r, shadow0_r};
            ch_valid_r <= 4'b1111;
         end else begin
            ch_valid_r <= 4'b0000;
         end
      end
   end
`else
   // Each accepted word lands directly in its channel field.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout_r     <= {(4*WIDTH){1'b0}};
         ch_valid_r <= 4'b0000;
      end else begin
         if (wr_en_s) begin
            dout_r[wr_ch_s*WIDTH +: WIDTH] <= din;
            ch_valid_r                     <= 4'b0001 << wr_ch_s;
         end else begin
            ch_valid_r <= 4'b0000;
         end
      end
   end
`endif

   assign dout       = dout_r;
   assign ch_valid   = ch_valid_r;
   assign frame_done = frame_done_r;
   assign sync_err   = sync_err_r;
   assign locked     = (state_r == ST_LOCKED);

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4 (WIDTH=8); expectations follow TDM_DEMUX_FRAME_LATCH_EN.
module tb_tdm_demux4;

   logic        clk;
   logic        rst_n;
   logic [7:0]  din;
   logic        din_valid;
   logic        frame_sync;
   logic [31:0] dout;
   logic [3:0]  ch_valid;
   logic        frame_done;
   logic        locked;
   logic        sync_err;

   int checks_r = 0;
   int errors_r = 0;

   tdm_demux4 #(.WIDTH(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .din        (din),
      .din_valid  (din_valid),
      .frame_sync (frame_sync),
      .dout       (dout),
      .ch_valid   (ch_valid),
      .frame_done (frame_done),
      .locked     (locked),
      .sync_err   (sync_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef TDM_DEMUX_FRAME_LATCH_EN
   localparam bit LATCH = 1'b1;
`else
   localparam bit LATCH = 1'b0;
`endif

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks_r++;
      if (obs !== exp) begin
         errors_r++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present one beat, let the edge take it, then look just after the edge.
   task automatic beat(input logic v, input logic s, input logic [7:0] d);
      din_valid  = v;
      frame_sync = s;
      din        = d;
      @(posedge clk);
      #1;
      din_valid  = 1'b0;
      frame_sync = 1'b0;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_chv"}, {28'd0, ch_valid}, 32'd0);
      chk({tag, "_fd"}, {31'd0, frame_done}, 32'd0);
      chk({tag, "_err"}, {31'd0, sync_err}, 32'd0);
   endtask

   logic [31:0] frame1;
   logic [31:0] exp_dout;

   initial begin
      rst_n = 1'b0; din = 8'h00; din_valid = 1'b0; frame_sync = 1'b0;
      frame1 = 32'hD4C3B2A1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("rst_dout", dout, 32'd0);
      chk("rst_locked", {31'd0, locked}, 32'd0);
      chk_idle("rst");

      // Partial frame, then asynchronous reset mid-frame after slot 1.
      beat(1'b1, 1'b1, 8'h11);
      beat(1'b1, 1'b0, 8'h22);
      chk("pre_rst_locked", {31'd0, locked}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_dout", dout, 32'd0);
      chk("midrst_locked", {31'd0, locked}, 32'd0);
      chk_idle("midrst");
      @(posedge clk);
      #1 rst_n = 1'b1;

      // HUNT discards beats without sync and sync without valid.
      for (int i = 0; i < 3; i++) begin
         beat(1'b1, 1'b0, 8'h5A + 8'(i));
         chk("hunt_dout", dout, 32'd0);
         chk("hunt_locked", {31'd0, locked}, 32'd0);
         chk_idle("hunt");
      end
      beat(1'b0, 1'b1, 8'h99);
      chk("nv_sync_locked", {31'd0, locked}, 32'd0);
      chk("nv_sync_chv", {28'd0, ch_valid}, 32'd0);

      // Clean frame.
      for (int i = 0; i < 4; i++) begin
         beat(1'b1, (i == 0), frame1[i*8 +: 8]);
         chk("clean_locked", {31'd0, locked}, 32'd1);
         chk("clean_err", {31'd0, sync_err}, 32'd0);
         if (LATCH) chk("clean_chv", {28'd0, ch_valid}, (i == 3) ? 32'hF : 32'h0);
         else       chk("clean_chv", {28'd0, ch_valid}, 32'd1 << i);
         chk("clean_fd", {31'd0, frame_done}, (i == 3) ? 32'd1 : 32'd0);
      end
      chk("clean_dout", dout, frame1);
      beat(1'b0, 1'b0, 8'h00);
      chk_idle("clean_after");
      chk("clean_after_locked", {31'd0, locked}, 32'd1);

      // Gapped valid: two idle cycles between beats.
      for (int i = 0; i < 4; i++) begin
         beat(1'b1, (i == 0), frame1[i*8 +: 8]);
         chk("gap_err", {31'd0, sync_err}, 32'd0);
         if (LATCH) chk("gap_chv", {28'd0, ch_valid}, (i == 3) ? 32'hF : 32'h0);
         else       chk("gap_chv", {28'd0, ch_valid}, 32'd1 << i);
         chk("gap_fd", {31'd0, frame_done}, (i == 3) ? 32'd1 : 32'd0);
         for (int g = 0; g < 2; g++) begin
            beat(1'b0, 1'b0, 8'hEE);
            chk_idle("gap_idle");
         end
      end
      chk("gap_dout", dout, frame1);

      // Early resync on the third beat.
      beat(1'b1, 1'b1, 8'h10);
      beat(1'b1, 1'b0, 8'h20);
      beat(1'b1, 1'b1, 8'h30);
      chk("resync_err", {31'd0, sync_err}, 32'd1);
      chk("resync_fd", {31'd0, frame_done}, 32'd0);
      chk("resync_locked", {31'd0, locked}, 32'd1);
      exp_dout = LATCH ? frame1 : 32'hD4C32030;
      chk("resync_dout", dout, exp_dout);
      chk("resync_chv", {28'd0, ch_valid}, LATCH ? 32'h0 : 32'h1);
      beat(1'b1, 1'b0, 8'h40);
      chk("resync_b1_err", {31'd0, sync_err}, 32'd0);
      chk("resync_b1_fd", {31'd0, frame_done}, 32'd0);
      beat(1'b1, 1'b0, 8'h50);
      chk("resync_b2_fd", {31'd0, frame_done}, 32'd0);
      beat(1'b1, 1'b0, 8'h60);
      chk("resync_b3_fd", {31'd0, frame_done}, 32'd1);
      chk("resync_b3_chv", {28'd0, ch_valid}, LATCH ? 32'hF : 32'h8);
      chk("resync_b3_dout", dout, 32'h60504030);
      beat(1'b0, 1'b0, 8'h00);
      chk_idle("resync_after");

      // Sync loss after a complete locked frame.
      beat(1'b1, 1'b0, 8'h77);
      chk("loss_err", {31'd0, sync_err}, 32'd1);
      chk("loss_locked", {31'd0, locked}, 32'd0);
      chk("loss_dout", dout, 32'h60504030);
      chk("loss_chv", {28'd0, ch_valid}, 32'd0);
      chk("loss_fd", {31'd0, frame_done}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         beat(1'b1, 1'b0, 8'h81 + 8'(i));
         chk("loss_tail_locked", {31'd0, locked}, 32'd0);
         chk("loss_tail_dout", dout, 32'h60504030);
         chk_idle("loss_tail");
      end

      $display("Result: errors=%0d of %0d checks", errors_r, checks_r);
      $finish;
   end

endmodule
